// File: rtl/ibex_rf_wr_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: grant source encoding,
// port widths and a small address helper.
package ibex_rf_wr_arbiter_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;

  typedef enum logic [2:0] {
    RF_WR_LSU  = 3'd0,
    RF_WR_HOLD = 3'd1,
    RF_WR_MD   = 3'd2,
    RF_WR_WB   = 3'd3,
    RF_WR_NONE = 3'd4
  } rf_wr_src_e;

  // x0 is hardwired to zero, so only non-zero destinations are real writes.
  function automatic logic rf_addr_nz(input logic [RegAddrW-1:0] addr);
    return (addr != {RegAddrW{1'b0}});
  endfunction

endpackage

// File: rtl/ibex_rf_wr_arbiter_if.sv
// Producer/consumer bundle around the register-file write port and decode read
// addresses. master = producers and decode, slave = the arbiter.
interface ibex_rf_wr_arbiter_if;
  import ibex_rf_wr_arbiter_pkg::*;

  logic                lsu_we_i;
  logic [RegAddrW-1:0] lsu_waddr_i;
  logic [DataW-1:0]    lsu_wdata_i;
  logic                wb_valid_i;
  logic                wb_ready_o;
  logic [RegAddrW-1:0] wb_waddr_i;
  logic [DataW-1:0]    wb_wdata_i;
  logic                md_valid_i;
  logic                md_ready_o;
  logic [RegAddrW-1:0] md_waddr_i;
  logic [DataW-1:0]    md_wdata_i;
  logic [RegAddrW-1:0] rf_raddr_a_i;
  logic [RegAddrW-1:0] rf_raddr_b_i;
  logic                rd_hazard_o;
  logic                rf_we_o;
  logic [RegAddrW-1:0] rf_waddr_o;
  logic [DataW-1:0]    rf_wdata_o;
  logic                hold_valid_o;

  modport master (
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output wb_valid_i, wb_waddr_i, wb_wdata_i,
    output md_valid_i, md_waddr_i, md_wdata_i,
    output rf_raddr_a_i, rf_raddr_b_i,
    input  wb_ready_o, md_ready_o, rd_hazard_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, hold_valid_o
  );

  modport slave (
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  wb_valid_i, wb_waddr_i, wb_wdata_i,
    input  md_valid_i, md_waddr_i, md_wdata_i,
    input  rf_raddr_a_i, rf_raddr_b_i,
    output wb_ready_o, md_ready_o, rd_hazard_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, hold_valid_o
  );

endinterface

// File: rtl/ibex_rf_wr_arbiter_chk.sv
// Protocol checker for the write-port arbiter: a writeback may only be captured
// into the hold buffer when it has actually been accepted.
module ibex_rf_wr_arbiter_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic lsu_we_i,
  input logic hold_valid_i,
  input logic wb_capture_i,
  input logic wb_ready_i
);

  // An occupied buffer displaced by an LSU write has no room for a new result.
  a_no_capture_without_ready: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(lsu_we_i && hold_valid_i && wb_capture_i && !wb_ready_i)
  );

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// Single register-file write port shared by LSU, hold buffer, mul/div and
// writeback, with a one-entry hold buffer and mul/div starvation guard.
module ibex_rf_wr_arbiter #(
  parameter int unsigned StarveLimit = 3
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ibex_rf_wr_arbiter_if.slave  bus
);
  import ibex_rf_wr_arbiter_pkg::*;

  localparam int unsigned   CntW      = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(StarveLimit);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  logic                hold_valid_q, hold_valid_d;
  logic [RegAddrW-1:0] hold_waddr_q, hold_waddr_d;
  logic [DataW-1:0]    hold_wdata_q, hold_wdata_d;
  logic [CntW-1:0]     md_wait_q, md_wait_d;

  rf_wr_src_e          grant_src;
  logic                md_starve;
  logic                wb_ready;
  logic                wb_capture;
  logic [RegAddrW-1:0] wr_addr;
  logic [DataW-1:0]    wr_data;

  assign md_starve = (md_wait_q == StarveMax);

  // Fixed-priority grant; the LSU can never be stalled so it always wins.
  always_comb begin
    grant_src = RF_WR_NONE;
    if (bus.lsu_we_i) begin
      grant_src = RF_WR_LSU;
    end else if (hold_valid_q) begin
      grant_src = RF_WR_HOLD;
    end else if (bus.md_valid_i && md_starve) begin
      grant_src = RF_WR_MD;
    end else if (bus.wb_valid_i) begin
      grant_src = RF_WR_WB;
    end else if (bus.md_valid_i) begin
      grant_src = RF_WR_MD;
    end else begin
      grant_src = RF_WR_NONE;
    end
  end

  // Write-port data mux driven by the grant.
  always_comb begin
    wr_addr = {RegAddrW{1'b0}};
    wr_data = {DataW{1'b0}};
    case (grant_src)
      RF_WR_LSU: begin
        wr_addr = bus.lsu_waddr_i;
        wr_data = bus.lsu_wdata_i;
      end
      RF_WR_HOLD: begin
        wr_addr = hold_waddr_q;
        wr_data = hold_wdata_q;
      end
      RF_WR_MD: begin
        wr_addr = bus.md_waddr_i;
        wr_data = bus.md_wdata_i;
      end
      RF_WR_WB: begin
        wr_addr = bus.wb_waddr_i;
        wr_data = bus.wb_wdata_i;
      end
      default: begin
        wr_addr = {RegAddrW{1'b0}};
        wr_data = {DataW{1'b0}};
      end
    endcase
  end

  // A draining buffer frees its slot in the same cycle, so writeback may refill it.
  assign wb_ready   = bus.wb_valid_i & (~hold_valid_q | (grant_src == RF_WR_HOLD));
  assign wb_capture = wb_ready & (grant_src != RF_WR_WB) & rf_addr_nz(bus.wb_waddr_i);

  // Hold buffer next state: capture has precedence over drain (refill case).
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_waddr_d = hold_waddr_q;
    hold_wdata_d = hold_wdata_q;
    if (wb_capture) begin
      hold_valid_d = 1'b1;
      hold_waddr_d = bus.wb_waddr_i;
      hold_wdata_d = bus.wb_wdata_i;
    end else if (grant_src == RF_WR_HOLD) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Starvation counter: counts consecutive denied mul/div cycles, saturating.
  always_comb begin
    md_wait_d = md_wait_q;
    if (!bus.md_valid_i || (grant_src == RF_WR_MD)) begin
      md_wait_d = {CntW{1'b0}};
    end else if (!md_starve) begin
      md_wait_d = md_wait_q + CntOne;
    end else begin
      md_wait_d = md_wait_q;
    end
  end

  // State registers; reset drops any held entry along with the flushed pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_waddr_q <= {RegAddrW{1'b0}};
      hold_wdata_q <= {DataW{1'b0}};
      md_wait_q    <= {CntW{1'b0}};
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_waddr_q <= hold_waddr_d;
      hold_wdata_q <= hold_wdata_d;
      md_wait_q    <= md_wait_d;
    end
  end

  assign bus.wb_ready_o   = wb_ready;
  assign bus.md_ready_o   = (grant_src == RF_WR_MD);
  assign bus.rf_we_o      = (grant_src != RF_WR_NONE) & rf_addr_nz(wr_addr);
  assign bus.rf_waddr_o   = wr_addr;
  assign bus.rf_wdata_o   = wr_data;
  assign bus.hold_valid_o = hold_valid_q;
  assign bus.rd_hazard_o  = hold_valid_q & rf_addr_nz(hold_waddr_q) &
                            ((hold_waddr_q == bus.rf_raddr_a_i) |
                             (hold_waddr_q == bus.rf_raddr_b_i));

  ibex_rf_wr_arbiter_chk u_chk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .lsu_we_i     (bus.lsu_we_i),
    .hold_valid_i (hold_valid_q),
    .wb_capture_i (wb_capture),
    .wb_ready_i   (wb_ready)
  );

endmodule
